lcd_text_fetch: RTL and testbench

LCD_TEXT_FETCH -- requirements
Module: lcd_text_fetch

---
 rtl/lcd_text_fetch.sv | 139 +++++++++++++
 tb/tb_lcd_text_fetch.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_fetch.sv
// Fetches one frame of text words from on-chip memory and streams the
// characters out one byte at a time over a valid/ready handshake.
module lcd_text_fetch #(
    parameter logic [10:0] BASE_DEFAULT = 11'h000,
    parameter int          NUM_WORDS    = 8,
    parameter bit          SANITIZE     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [10:0] base_addr,
    output logic        busy,
    output logic        done,
    output logic [10:0] mem_address,
    output logic        mem_chipselect,
    output logic        mem_write,
    output logic [3:0]  mem_byteenable,
    output logic        mem_clken,
    input  logic [31:0] mem_readdata,
    output logic [7:0]  char_data,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        char_last,
    output logic [5:0]  char_index
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        EMIT    = 3'd3,
        FINISH  = 3'd4
    } state_t;

    localparam logic [4:0] LAST_WORD = 5'(NUM_WORDS - 1);

    state_t      state_q, state_d;
    logic [10:0] base_q, base_d;
    logic [3:0]  word_q, word_d;
    logic [1:0]  byte_q, byte_d;
    logic [31:0] buf_q, buf_d;
    logic [7:0]  raw_byte;
    logic        in_emit;
    logic        in_mem;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            base_q  <= 11'd0;
            word_q  <= 4'd0;
            byte_q  <= 2'd0;
            buf_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            word_q  <= word_d;
            byte_q  <= byte_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        word_d  = word_q;
        byte_d  = byte_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = (base_addr == 11'd0) ? BASE_DEFAULT : base_addr;
                    word_d  = 4'd0;
                    byte_d  = 2'd0;
                    state_d = READ;
                end
            end
            READ: state_d = CAPTURE;
            CAPTURE: begin
                buf_d   = mem_readdata;
                byte_d  = 2'd0;
                state_d = EMIT;
            end
            EMIT: begin
                if (char_ready) begin
                    byte_d = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        if ({1'b0, word_q} < LAST_WORD) begin
                            word_d  = word_q + 4'd1;
                            state_d = READ;
                        end else begin
                            state_d = FINISH;
                        end
                    end
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Little-endian byte select from the captured word
    always_comb begin
        raw_byte = buf_q[7:0];
        case (byte_q)
            2'd0: raw_byte = buf_q[7:0];
            2'd1: raw_byte = buf_q[15:8];
            2'd2: raw_byte = buf_q[23:16];
            2'd3: raw_byte = buf_q[31:24];
            default: raw_byte = buf_q[7:0];
        endcase
    end

    assign in_emit = (state_q == EMIT);
    assign in_mem  = (state_q == READ) || (state_q == CAPTURE);

    assign busy           = (state_q != IDLE);
    assign done           = (state_q == FINISH);
    assign mem_address    = in_mem ? (base_q + {7'd0, word_q}) : 11'd0;
    assign mem_chipselect = (state_q == READ);
    assign mem_clken      = in_mem;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;

    always_comb begin
        char_data = 8'd0;
        if (in_emit) begin
            if (SANITIZE && ((raw_byte < 8'h20) || (raw_byte > 8'h7E)))
                char_data = 8'h20;
            else
                char_data = raw_byte;
        end
    end

    assign char_valid = in_emit;
    assign char_index = in_emit ? {word_q, byte_q} : 6'd0;
    assign char_last  = in_emit && ({1'b0, word_q} == LAST_WORD)
                        && (byte_q == 2'd3);

endmodule

// File: tb/tb_lcd_text_fetch.sv
// Directed bench for lcd_text_fetch: frame order, address wrap, stalls,
// start/reset mid-frame and character sanitising.
module tb_lcd_text_fetch;

    logic        clk = 1'b0;
    logic        reset, start, char_ready;
    logic [10:0] base_addr;
    logic        busy, done, mem_chipselect, mem_write, mem_clken;
    logic [10:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata;
    logic [7:0]  char_data;
    logic        char_valid, char_last;
    logic [5:0]  char_index;

    logic        busy0, done0, cs0, wr0, clken0, valid0, last0;
    logic [10:0] addr0;
    logic [3:0]  be0;
    logic [31:0] rdata0;
    logic [7:0]  data0;
    logic [5:0]  idx0;

    logic [31:0] mem [0:2047];

    int total = 0;
    int bad   = 0;
    int rd_n  = 0;
    int done_n = 0;
    logic [10:0] rd_addr [0:255];

    logic [7:0] got_data [0:63];
    logic [7:0] got_data0 [0:63];
    logic [5:0] got_idx [0:63];
    logic       got_last [0:63];

    always #5 clk = ~clk;

    lcd_text_fetch dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done), .mem_address(mem_address),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata), .char_data(char_data),
        .char_valid(char_valid), .char_ready(char_ready),
        .char_last(char_last), .char_index(char_index)
    );

    lcd_text_fetch #(.SANITIZE(1'b0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .busy(busy0), .done(done0), .mem_address(addr0),
        .mem_chipselect(cs0), .mem_write(wr0),
        .mem_byteenable(be0), .mem_clken(clken0),
        .mem_readdata(rdata0), .char_data(data0),
        .char_valid(valid0), .char_ready(char_ready),
        .char_last(last0), .char_index(idx0)
    );

    // One-clock-latency synchronous memory model
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) mem_readdata <= mem[mem_address];
        if (cs0 && clken0) rdata0 <= mem[addr0];
    end

    always @(posedge clk) begin
        if (mem_chipselect) begin
            rd_addr[rd_n[7:0]] <= mem_address;
            rd_n <= rd_n + 1;
        end
        if (done) done_n <= done_n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Records accepted bytes; called at a negedge, returns at the negedge
    // just before the posedge that accepts the n-th byte.
    task automatic collect(input int n);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < 400) begin
            if (char_valid && char_ready) begin
                got_data[got]  = char_data;
                got_data0[got] = data0;
                got_idx[got]   = char_index;
                got_last[got]  = char_last;
                got++;
            end
            if (got < n) begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("collect_count", got, n);
    endtask

    task automatic wait_index(input logic [5:0] idx);
        int cyc = 0;
        while (!(char_valid && char_index == idx) && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk("wait_index", char_index, idx);
    endtask

    task automatic kick(input logic [10:0] b);
        base_addr = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        base_addr = 11'd0;
    endtask

    int rd0, dn0;

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 32'd0;
        for (int n = 0; n < 8; n++)
            mem[11'h010 + n] = 32'h44434241 + 32'h04040404 * n;
        mem[11'h100] = 32'h7E0A1F20;

        reset = 1'b1;
        start = 1'b0;
        char_ready = 1'b1;
        base_addr = 11'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", char_valid, 0);
        chk("rst_last", char_last, 0);
        chk("rst_cs", mem_chipselect, 0);
        chk("rst_clken", mem_clken, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_data", char_data, 0);
        chk("rst_index", char_index, 0);
        chk("rst_write", mem_write, 0);
        chk("rst_be", mem_byteenable, 4'hF);
        chk("rst_reads", rd_n, 0);

        // Full frame at 0x010 with ready held high
        kick(11'h010);
        chk("f1_busy", busy, 1);
        chk("f1_cs", mem_chipselect, 1);
        chk("f1_addr0", mem_address, 11'h010);
        collect(32);
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("f1_data%0d", k), got_data[k], 8'h41 + k);
            chk($sformatf("f1_idx%0d", k), got_idx[k], k);
            chk($sformatf("f1_last%0d", k), got_last[k], k == 31);
        end
        @(negedge clk);
        chk("f1_done", done, 1);
        chk("f1_valid_drop", char_valid, 0);
        @(negedge clk);
        chk("f1_done_pulse", done, 0);
        chk("f1_busy_end", busy, 0);
        chk("f1_done_n", done_n, 1);
        chk("f1_reads", rd_n, 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("f1_raddr%0d", i), rd_addr[i], 11'h010 + i);

        // Address wrap at the top of memory
        rd0 = rd_n;
        kick(11'h7FE);
        collect(32);
        repeat (3) @(negedge clk);
        chk("wrap_reads", rd_n - rd0, 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("wrap_raddr%0d", i), rd_addr[rd0 + i],
                (11'h7FE + i) & 11'h7FF);

        // Consumer stall at index 2
        rd0 = rd_n;
        kick(11'h010);
        wait_index(6'd2);
        char_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_data", char_data, 8'h43);
            chk("stall_index", char_index, 2);
            chk("stall_cs", mem_chipselect, 0);
        end
        chk("stall_reads", rd_n - rd0, 1);
        char_ready = 1'b1;
        collect(30);
        chk("stall_resume_idx", got_idx[0], 2);
        chk("stall_resume_data", got_data[0], 8'h43);
        chk("stall_end_idx", got_idx[29], 31);
        repeat (3) @(negedge clk);

        // start mid-frame is ignored
        dn0 = done_n;
        rd0 = rd_n;
        kick(11'h010);
        wait_index(6'd10);
        base_addr = 11'h100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        base_addr = 11'd0;
        collect(21);
        chk("ign_first_idx", got_idx[0], 11);
        chk("ign_first_data", got_data[0], 8'h4C);
        repeat (6) @(negedge clk);
        chk("ign_done_n", done_n - dn0, 1);
        chk("ign_reads", rd_n - rd0, 8);
        chk("ign_busy", busy, 0);

        // reset mid-frame aborts without done
        dn0 = done_n;
        kick(11'h010);
        wait_index(6'd10);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", char_valid, 0);
        repeat (4) @(negedge clk);
        chk("abort_idle", busy, 0);
        chk("abort_done_n", done_n - dn0, 0);
        kick(11'h010);
        collect(1);
        chk("restart_idx", got_idx[0], 0);
        chk("restart_data", got_data[0], 8'h41);
        @(negedge clk);
        collect(31);
        repeat (3) @(negedge clk);

        // Sanitise on/off
        kick(11'h100);
        collect(32);
        chk("san1_b0", got_data[0], 8'h20);
        chk("san1_b1", got_data[1], 8'h20);
        chk("san1_b2", got_data[2], 8'h20);
        chk("san1_b3", got_data[3], 8'h7E);
        chk("san1_b4", got_data[4], 8'h20);
        chk("san0_b0", got_data0[0], 8'h20);
        chk("san0_b1", got_data0[1], 8'h1F);
        chk("san0_b2", got_data0[2], 8'h0A);
        chk("san0_b3", got_data0[3], 8'h7E);
        chk("san0_b4", got_data0[4], 8'h00);
        chk("san_last_idx", got_idx[31], 31);
        chk("san_last_flag", got_last[31], 1);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
